// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - EXE command encodings, flag indices and decode helpers
package arm_pkg;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic cmd_defined(input logic [3:0] cmd);
    return cmd inside {EXE_MOV, EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC,
                       EXE_AND, EXE_ORR, EXE_EOR, EXE_MVN};
  endfunction

  // Only the adder/subtractor ops own C and V; the rest leave them alone.
  function automatic logic cmd_is_arith(input logic [3:0] cmd);
    return cmd inside {EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC};
  endfunction

endpackage

// File: rtl/exe_alu_stage_if.sv
// rtl/exe_alu_stage_if.sv - ID/EXE input bundle and EXE/MEM output bundle
interface exe_alu_stage_if #(
  parameter int DW = 32,
  parameter int RW = 4
);
  logic          stall;
  logic          flush;
  logic          in_valid;
  logic [3:0]    exe_cmd;
  logic          s_bit;
  logic [DW-1:0] val1;
  logic [DW-1:0] val2;
  logic [DW-1:0] st_val;
  logic          wb_en;
  logic          mem_r_en;
  logic          mem_w_en;
  logic [RW-1:0] dest;

  logic          out_valid;
  logic [DW-1:0] alu_res;
  logic          out_wb_en;
  logic          out_mem_r_en;
  logic          out_mem_w_en;
  logic [RW-1:0] out_dest;
  logic [DW-1:0] out_st_val;
  logic [3:0]    status;

  modport master (
    output stall, flush, in_valid, exe_cmd, s_bit, val1, val2, st_val,
           wb_en, mem_r_en, mem_w_en, dest,
    input  out_valid, alu_res, out_wb_en, out_mem_r_en, out_mem_w_en,
           out_dest, out_st_val, status
  );

  modport slave (
    input  stall, flush, in_valid, exe_cmd, s_bit, val1, val2, st_val,
           wb_en, mem_r_en, mem_w_en, dest,
    output out_valid, alu_res, out_wb_en, out_mem_r_en, out_mem_w_en,
           out_dest, out_st_val, status
  );
endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU: result plus raw NZCV for every command
module alu_core
  import arm_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [3:0]    i_exe_cmd,
  input  logic [DW-1:0] i_val1,
  input  logic [DW-1:0] i_val2,
  input  logic          i_c_in,
  output logic [DW-1:0] o_res,
  output logic          o_n,
  output logic          o_z,
  output logic          o_c,
  output logic          o_v
);

  logic [DW:0] w_sum;
  logic        w_is_sub;

  always_comb begin
    w_sum    = '0;
    w_is_sub = 1'b0;
    case (i_exe_cmd)
      EXE_MOV: w_sum = {1'b0, i_val2};
      EXE_MVN: w_sum = {1'b0, ~i_val2};
      EXE_ADD: w_sum = {1'b0, i_val1} + {1'b0, i_val2};
      EXE_ADC: w_sum = {1'b0, i_val1} + {1'b0, i_val2} + {{DW{1'b0}}, i_c_in};
      EXE_SUB: begin
        w_sum    = {1'b0, i_val1} - {1'b0, i_val2};
        w_is_sub = 1'b1;
      end
      // Borrow-in is the inverse of the registered carry.
      EXE_SBC: begin
        w_sum    = {1'b0, i_val1} - {1'b0, i_val2} - {{DW{1'b0}}, ~i_c_in};
        w_is_sub = 1'b1;
      end
      EXE_AND: w_sum = {1'b0, i_val1 & i_val2};
      EXE_ORR: w_sum = {1'b0, i_val1 | i_val2};
      EXE_EOR: w_sum = {1'b0, i_val1 ^ i_val2};
      default: w_sum = '0;
    endcase
  end

  always_comb begin
    o_res = w_sum[DW-1:0];
    o_n   = w_sum[DW-1];
    o_z   = (w_sum[DW-1:0] == '0);
    if (w_is_sub) begin
      o_c = ~w_sum[DW];
      o_v = (i_val1[DW-1] != i_val2[DW-1]) && (w_sum[DW-1] != i_val1[DW-1]);
    end else begin
      o_c = w_sum[DW];
      o_v = (i_val1[DW-1] == i_val2[DW-1]) && (w_sum[DW-1] != i_val1[DW-1]);
    end
  end

endmodule

// File: rtl/exe_alu_stage.sv
// rtl/exe_alu_stage.sv - execute stage: ALU, status register, EXE/MEM register
module exe_alu_stage
  import arm_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  exe_alu_stage_if.slave    bus
);

  logic [DW-1:0] w_res;
  logic          w_n, w_z, w_c, w_v;
  logic          w_capture;
  logic [3:0]    w_status_nxt;

  logic          r_valid;
  logic [DW-1:0] r_res;
  logic          r_wb_en;
  logic          r_mem_r_en;
  logic          r_mem_w_en;
  logic [RW-1:0] r_dest;
  logic [DW-1:0] r_st_val;
  logic [3:0]    r_status;

  alu_core #(.DW(DW)) u_alu (
    .i_exe_cmd (bus.exe_cmd),
    .i_val1    (bus.val1),
    .i_val2    (bus.val2),
    .i_c_in    (r_status[FLAG_C]),
    .o_res     (w_res),
    .o_n       (w_n),
    .o_z       (w_z),
    .o_c       (w_c),
    .o_v       (w_v)
  );

  assign w_capture = bus.in_valid & bus.s_bit & ~bus.stall & ~bus.flush
                   & cmd_defined(bus.exe_cmd);

  always_comb begin
    w_status_nxt         = r_status;
    w_status_nxt[FLAG_N] = w_n;
    w_status_nxt[FLAG_Z] = w_z;
    if (cmd_is_arith(bus.exe_cmd)) begin
      w_status_nxt[FLAG_C] = w_c;
      w_status_nxt[FLAG_V] = w_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= '0;
    end else if (w_capture) begin
      r_status <= w_status_nxt;
    end
  end

  // Flush outranks stall so a squashed instruction never lingers in a frozen stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_res      <= '0;
      r_wb_en    <= 1'b0;
      r_mem_r_en <= 1'b0;
      r_mem_w_en <= 1'b0;
      r_dest     <= '0;
      r_st_val   <= '0;
    end else if (bus.flush) begin
      r_valid    <= 1'b0;
      r_res      <= '0;
      r_wb_en    <= 1'b0;
      r_mem_r_en <= 1'b0;
      r_mem_w_en <= 1'b0;
      r_dest     <= '0;
      r_st_val   <= '0;
    end else if (!bus.stall) begin
      r_valid    <= bus.in_valid;
      r_res      <= w_res;
      r_wb_en    <= bus.wb_en    & bus.in_valid;
      r_mem_r_en <= bus.mem_r_en & bus.in_valid;
      r_mem_w_en <= bus.mem_w_en & bus.in_valid;
      r_dest     <= bus.dest;
      r_st_val   <= bus.st_val;
    end
  end

  assign bus.out_valid    = r_valid;
  assign bus.alu_res      = r_res;
  assign bus.out_wb_en    = r_wb_en;
  assign bus.out_mem_r_en = r_mem_r_en;
  assign bus.out_mem_w_en = r_mem_w_en;
  assign bus.out_dest     = r_dest;
  assign bus.out_st_val   = r_st_val;
  assign bus.status       = r_status;

endmodule

// File: tb/tb_exe_alu_stage.sv
// tb/tb_exe_alu_stage.sv - vector table with scoreboard plus stall/flush/reset sequences
module tb_exe_alu_stage;
  import arm_pkg::*;

  typedef struct {
    logic [3:0]  cmd;
    logic        s;
    logic        vin;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] res;
    logic [3:0]  st;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [31:0] res;
    logic [3:0]  st;
    logic [3:0]  dest;
    logic [31:0] st_val;
    logic        wb;
    logic        mr;
    logic        mw;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  vec_t vecs[$];
  exp_t exp_q[$];

  exe_alu_stage_if #(.DW(32), .RW(4)) bus ();

  exe_alu_stage #(.DW(32), .RW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] cmd, input logic s, input logic vin,
                              input logic [31:0] v1, input logic [31:0] v2,
                              input logic [31:0] res, input logic [3:0] st);
    vec_t v;
    v.cmd = cmd; v.s = s; v.vin = vin; v.v1 = v1; v.v2 = v2; v.res = res; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] cmd, input logic s, input logic vin,
                       input logic [31:0] v1, input logic [31:0] v2,
                       input logic [3:0] dest, input logic [31:0] stv,
                       input logic wb, input logic mr, input logic mw);
    bus.exe_cmd  = cmd;
    bus.s_bit    = s;
    bus.in_valid = vin;
    bus.val1     = v1;
    bus.val2     = v2;
    bus.dest     = dest;
    bus.st_val   = stv;
    bus.wb_en    = wb;
    bus.mem_r_en = mr;
    bus.mem_w_en = mw;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    #3;
    chk("rst_valid",  {31'b0, bus.out_valid}, 32'h0);
    chk("rst_res",    bus.alu_res,            32'h0);
    chk("rst_status", {28'b0, bus.status},    32'h0);
    chk("rst_wb",     {31'b0, bus.out_wb_en}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back(mk(EXE_ADD, 1, 1, 32'd5,         32'd7,         32'd12,        4'b0000));
    vecs.push_back(mk(EXE_SUB, 1, 1, 32'd3,         32'd5,         32'hFFFFFFFE,  4'b1000));
    vecs.push_back(mk(EXE_SUB, 1, 1, 32'd5,         32'd5,         32'h0,         4'b0110));
    vecs.push_back(mk(EXE_ADD, 1, 1, 32'h7FFFFFFF,  32'd1,         32'h80000000,  4'b1001));
    vecs.push_back(mk(EXE_ADD, 1, 1, 32'hFFFFFFFF,  32'd1,         32'h0,         4'b0110));
    vecs.push_back(mk(EXE_ADC, 0, 1, 32'd0,         32'd0,         32'd1,         4'b0110));
    vecs.push_back(mk(EXE_ADD, 1, 1, 32'h80000000,  32'h80000001,  32'd1,         4'b0011));
    vecs.push_back(mk(EXE_MOV, 1, 1, 32'd9,         32'd0,         32'h0,         4'b0111));
    vecs.push_back(mk(EXE_MOV, 0, 1, 32'd9,         32'h80000000,  32'h80000000,  4'b0111));
    vecs.push_back(mk(EXE_MVN, 1, 1, 32'd0,         32'd0,         32'hFFFFFFFF,  4'b1011));
    vecs.push_back(mk(EXE_AND, 1, 1, 32'hF0F0,      32'h0FF0,      32'h00F0,      4'b0011));
    vecs.push_back(mk(EXE_ORR, 0, 1, 32'hF000,      32'h000F,      32'hF00F,      4'b0011));
    vecs.push_back(mk(EXE_EOR, 1, 1, 32'hFFFF,      32'hFFFF,      32'h0,         4'b0111));
    vecs.push_back(mk(EXE_SBC, 1, 1, 32'd10,        32'd3,         32'd7,         4'b0010));
    vecs.push_back(mk(EXE_SUB, 1, 1, 32'd3,         32'd5,         32'hFFFFFFFE,  4'b1000));
    vecs.push_back(mk(EXE_SBC, 1, 1, 32'd10,        32'd3,         32'd6,         4'b0010));
    vecs.push_back(mk(4'hF,    1, 1, 32'd5,         32'd7,         32'h0,         4'b0010));
    vecs.push_back(mk(EXE_ADC, 1, 1, 32'd5,         32'd6,         32'd12,        4'b0000));
    vecs.push_back(mk(EXE_ADD, 1, 0, 32'hFFFFFFFF,  32'd1,         32'h0,         4'b0000));

    for (int i = 0; i < vecs.size(); i++) begin
      logic [3:0]  d;
      logic [31:0] sv;
      logic        mr, mw;
      d  = 4'(i);
      sv = 32'hA000_0000 + 32'(i);
      mr = (i % 2) == 1;
      mw = (i % 4) >= 2;
      drive(vecs[i].cmd, vecs[i].s, vecs[i].vin, vecs[i].v1, vecs[i].v2, d, sv, 1'b1, mr, mw);
      e.valid  = vecs[i].vin;
      e.res    = vecs[i].res;
      e.st     = vecs[i].st;
      e.dest   = d;
      e.st_val = sv;
      e.wb     = vecs[i].vin;
      e.mr     = mr & vecs[i].vin;
      e.mw     = mw & vecs[i].vin;
      exp_q.push_back(e);
      tick();
      e = exp_q.pop_front();
      chk($sformatf("v%0d_valid", i),  {31'b0, bus.out_valid}, {31'b0, e.valid});
      chk($sformatf("v%0d_status", i), {28'b0, bus.status},    {28'b0, e.st});
      chk($sformatf("v%0d_wb", i),     {31'b0, bus.out_wb_en}, {31'b0, e.wb});
      chk($sformatf("v%0d_mem", i),    {30'b0, bus.out_mem_r_en, bus.out_mem_w_en},
                                       {30'b0, e.mr, e.mw});
      if (e.valid) begin
        chk($sformatf("v%0d_res", i),    bus.alu_res,         e.res);
        chk($sformatf("v%0d_dest", i),   {28'b0, bus.out_dest}, {28'b0, e.dest});
        chk($sformatf("v%0d_stval", i),  bus.out_st_val,      e.st_val);
      end
    end

    drive(EXE_SUB, 1, 1, 32'd9, 32'd4, 4'd5, 32'h55, 1'b1, 1'b0, 1'b0);
    tick();
    chk("stall_load_res",    bus.alu_res,         32'd5);
    chk("stall_load_status", {28'b0, bus.status}, 32'b0010);
    bus.stall = 1'b1;
    drive(EXE_ADD, 1, 1, 32'hFFFFFFFF, 32'd1, 4'd7, 32'h77, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall%0d_res", k),    bus.alu_res,            32'd5);
      chk($sformatf("stall%0d_status", k), {28'b0, bus.status},    32'b0010);
      chk($sformatf("stall%0d_dest", k),   {28'b0, bus.out_dest},  32'd5);
      chk($sformatf("stall%0d_valid", k),  {31'b0, bus.out_valid}, 32'd1);
    end
    bus.flush = 1'b1;
    tick();
    chk("flush_valid",  {31'b0, bus.out_valid}, 32'd0);
    chk("flush_wb",     {31'b0, bus.out_wb_en}, 32'd0);
    chk("flush_res",    bus.alu_res,            32'd0);
    chk("flush_status", {28'b0, bus.status},    32'b0010);
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    drive(EXE_MOV, 1, 1, 32'd0, 32'h1234, 4'd3, 32'h99, 1'b1, 1'b0, 1'b1);
    tick();
    chk("pre_rst_res",    bus.alu_res,         32'h1234);
    chk("pre_rst_status", {28'b0, bus.status}, 32'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_res",    bus.alu_res,               32'h0);
    chk("async_rst_status", {28'b0, bus.status},       32'h0);
    chk("async_rst_valid",  {31'b0, bus.out_valid},    32'h0);
    chk("async_rst_ctrl",   {29'b0, bus.out_wb_en, bus.out_mem_r_en, bus.out_mem_w_en}, 32'h0);
    chk("async_rst_data",   bus.out_st_val | {28'b0, bus.out_dest}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(EXE_ADD, 1, 1, 32'd5, 32'd7, 4'd1, 32'h1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("post_rst_res",    bus.alu_res,         32'd12);
    chk("post_rst_status", {28'b0, bus.status}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
